// File: rtl/duty_button_conditioner.sv
// Push-button front end for the PWM duty controller: synchronises and debounces
// the increase/decrease buttons and emits one-cycle, auto-repeating command pulses.
module duty_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 20000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_db,
  output logic dec_db
);

  localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  // Bit 0 is the increase button, bit 1 the decrease button throughout.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_q;
  logic [1:0]    pulse;
  logic          conflict;
  logic [CW-1:0] cnt   [2];
  logic [TW-1:0] timer [2];
  state_t        state [2];

  assign raw      = {btn_dec_raw, btn_inc_raw};
  assign conflict = db[0] & db[1];

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update from pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press/hold/repeat FSMs. Rising-edge detection on db means a button that
  // survives a conflict must be released and pressed again to pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q  <= '0;
      pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
      end
    end else begin
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (conflict) begin
          state[i] <= IDLE;
          timer[i] <= '0;
        end else begin
          case (state[i])
            IDLE: begin
              if (db[i] && !db_q[i]) begin
                pulse[i] <= 1'b1;
                timer[i] <= '0;
                state[i] <= HOLD;
              end
            end
            HOLD: begin
              if (!db[i]) begin
                state[i] <= IDLE;
                timer[i] <= '0;
              end else if (REPEAT_EN && timer[i] == HOLD_LAST) begin
                pulse[i] <= 1'b1;
                timer[i] <= '0;
                state[i] <= REPEAT;
              end else if (REPEAT_EN) begin
                timer[i] <= timer[i] + 1'b1;
              end
            end
            REPEAT: begin
              if (!db[i]) begin
                state[i] <= IDLE;
                timer[i] <= '0;
              end else if (timer[i] == REPEAT_LAST) begin
                pulse[i] <= 1'b1;
                timer[i] <= '0;
              end else begin
                timer[i] <= timer[i] + 1'b1;
              end
            end
            default: begin
              state[i] <= IDLE;
              timer[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign inc_pulse = pulse[0];
  assign dec_pulse = pulse[1];
  assign inc_db    = db[0];
  assign dec_db    = db[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Directed bench for duty_button_conditioner with short debounce/hold/repeat
// times; a second instance has auto-repeat disabled.
module tb_duty_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inc_raw = 1'b0;
  logic dec_raw = 1'b0;
  logic nr_dec_raw = 1'b0;
  logic inc_pulse, dec_pulse, inc_db, dec_db;
  logic nr_inc_pulse, nr_dec_pulse, nr_inc_db, nr_dec_db;

  int vectors = 0;
  int miscompares = 0;

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_inc_raw(inc_raw), .btn_dec_raw(dec_raw),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .inc_db(inc_db), .dec_db(dec_db)
  );

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst), .btn_inc_raw(inc_raw), .btn_dec_raw(nr_dec_raw),
    .inc_pulse(nr_inc_pulse), .dec_pulse(nr_dec_pulse), .inc_db(nr_inc_db), .dec_db(nr_dec_db)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses are never simultaneous and never wider than one cycle.
  logic inc_prev = 1'b0, dec_prev = 1'b0, nr_dec_prev = 1'b0;
  always @(negedge clk) begin
    vectors++;
    if ((inc_pulse & dec_pulse) !== 1'b0) begin
      miscompares++;
      $display("FAIL excl t=%0t got inc=%b dec=%b exp not both", $time, inc_pulse, dec_pulse);
    end
    vectors++;
    if ((inc_pulse & inc_prev) !== 1'b0) begin
      miscompares++;
      $display("FAIL inc_width t=%0t got 2-cycle pulse exp 1", $time);
    end
    vectors++;
    if ((dec_pulse & dec_prev) !== 1'b0) begin
      miscompares++;
      $display("FAIL dec_width t=%0t got 2-cycle pulse exp 1", $time);
    end
    vectors++;
    if ((nr_dec_pulse & nr_dec_prev) !== 1'b0) begin
      miscompares++;
      $display("FAIL nr_dec_width t=%0t got 2-cycle pulse exp 1", $time);
    end
    inc_prev    = inc_pulse;
    dec_prev    = dec_pulse;
    nr_dec_prev = nr_dec_pulse;
  end

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    step();
    vectors++;
    if ({inc_pulse, dec_pulse, inc_db, dec_db, nr_inc_pulse, nr_dec_pulse} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {inc_pulse, dec_pulse, inc_db, dec_db, nr_inc_pulse, nr_dec_pulse});
    end
    rst = 1'b0;
  endtask

  // Each loop iteration drives the input for edge cyc, then samples just after it.
  task automatic test_single_press();
    logic exp_p, exp_db;
    for (int cyc = 0; cyc < 25; cyc++) begin
      inc_raw = (cyc < 10);
      step();
      exp_p  = (cyc == 6);
      exp_db = (cyc >= 5 && cyc < 15);
      vectors++;
      if (inc_pulse !== exp_p) begin
        miscompares++;
        $display("FAIL t1_inc_pulse cyc=%0d got=%b exp=%b", cyc, inc_pulse, exp_p);
      end
      vectors++;
      if (inc_db !== exp_db) begin
        miscompares++;
        $display("FAIL t1_inc_db cyc=%0d got=%b exp=%b", cyc, inc_db, exp_db);
      end
      vectors++;
      if (dec_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL t1_dec_pulse cyc=%0d got=%b exp=0", cyc, dec_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    logic pattern [0:18];
    logic exp_p, exp_db;
    pattern = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b0};
    for (int cyc = 0; cyc < 45; cyc++) begin
      inc_raw = (cyc < 19) ? pattern[cyc] : (cyc < 31);
      step();
      exp_p  = (cyc == 25);
      exp_db = (cyc >= 24 && cyc < 36);
      vectors++;
      if (inc_pulse !== exp_p) begin
        miscompares++;
        $display("FAIL t2_inc_pulse cyc=%0d got=%b exp=%b", cyc, inc_pulse, exp_p);
      end
      vectors++;
      if (inc_db !== exp_db) begin
        miscompares++;
        $display("FAIL t2_inc_db cyc=%0d got=%b exp=%b", cyc, inc_db, exp_db);
      end
    end
  endtask

  task automatic test_repeat();
    logic exp_p, exp_nr;
    for (int cyc = 0; cyc < 80; cyc++) begin
      dec_raw    = (cyc < 60);
      nr_dec_raw = (cyc < 60);
      step();
      exp_p  = (cyc == 6) || (cyc >= 26 && cyc <= 58 && ((cyc - 26) % 8) == 0);
      exp_nr = (cyc == 6);
      vectors++;
      if (dec_pulse !== exp_p) begin
        miscompares++;
        $display("FAIL t3_dec_pulse cyc=%0d got=%b exp=%b", cyc, dec_pulse, exp_p);
      end
      vectors++;
      if (nr_dec_pulse !== exp_nr) begin
        miscompares++;
        $display("FAIL t3_norepeat_dec_pulse cyc=%0d got=%b exp=%b", cyc, nr_dec_pulse, exp_nr);
      end
      vectors++;
      if (inc_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL t3_inc_pulse cyc=%0d got=%b exp=0", cyc, inc_pulse);
      end
    end
  endtask

  task automatic test_conflict();
    logic exp_idb, exp_ddb, exp_p;
    for (int cyc = 0; cyc < 50; cyc++) begin
      inc_raw = (cyc < 40);
      dec_raw = (cyc < 30);
      step();
      exp_idb = (cyc >= 5 && cyc < 45);
      exp_ddb = (cyc >= 5 && cyc < 35);
      vectors++;
      if ({inc_pulse, dec_pulse} !== 2'b00) begin
        miscompares++;
        $display("FAIL t4_conflict_pulses cyc=%0d got=%b exp=00", cyc, {inc_pulse, dec_pulse});
      end
      vectors++;
      if ({inc_db, dec_db} !== {exp_idb, exp_ddb}) begin
        miscompares++;
        $display("FAIL t4_db cyc=%0d got=%b exp=%b", cyc, {inc_db, dec_db}, {exp_idb, exp_ddb});
      end
    end
    for (int cyc = 0; cyc < 25; cyc++) begin
      inc_raw = (cyc < 10);
      step();
      exp_p = (cyc == 6);
      vectors++;
      if (inc_pulse !== exp_p) begin
        miscompares++;
        $display("FAIL t4_repress_inc_pulse cyc=%0d got=%b exp=%b", cyc, inc_pulse, exp_p);
      end
    end
  endtask

  task automatic test_reset_while_held();
    logic exp_p, exp_db;
    for (int cyc = 0; cyc < 70; cyc++) begin
      inc_raw = (cyc < 50);
      rst     = (cyc == 37);
      step();
      exp_p  = (cyc == 6) || (cyc == 26) || (cyc == 34) || (cyc == 44);
      exp_db = (cyc >= 5 && cyc < 37) || (cyc >= 43 && cyc < 55);
      vectors++;
      if (inc_pulse !== exp_p) begin
        miscompares++;
        $display("FAIL t5_inc_pulse cyc=%0d got=%b exp=%b", cyc, inc_pulse, exp_p);
      end
      vectors++;
      if (inc_db !== exp_db) begin
        miscompares++;
        $display("FAIL t5_inc_db cyc=%0d got=%b exp=%b", cyc, inc_db, exp_db);
      end
      if (cyc == 37) begin
        vectors++;
        if ({inc_pulse, dec_pulse, inc_db, dec_db} !== 4'b0) begin
          miscompares++;
          $display("FAIL t5_after_reset got=%b exp=0000", {inc_pulse, dec_pulse, inc_db, dec_db});
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_repeat();
    test_conflict();
    test_reset_while_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
